// File: rtl/calculadora_bcd_serial.sv
// Sequential BCD calculator: add/subtract/multiply two unsigned operands, then serial double-dabble to DIGITS packed BCD digits.
// Optional multiplier for op 10 is built only when CALC_MUL_EN is defined.
module calculadora_bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic                  o1,
  input  logic                  o0,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sinal,
  output logic                  busy,
  output logic                  done,
  output logic                  erro,
  output logic                  ovf
);

  localparam int MW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [MW-1:0]    mag;
  logic [BW-1:0]    shift;
  logic [CW-1:0]    cnt;
  logic             neg_r;
  logic             err_r;
  logic             sticky;

  logic [MW-1:0]    calc_mag;
  logic             calc_neg;
  logic             calc_err;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    shift_next;
  logic [MW-1:0]    mag_next;
  logic             out_bit;

  // Magnitude, sign and error of the latched operation, taken once in CALC.
  always_comb begin
    calc_mag = '0;
    calc_neg = 1'b0;
    calc_err = 1'b0;
    case (op_r)
      2'b00: calc_mag = MW'(a_r) + MW'(b_r);
      2'b01: begin
        if (a_r >= b_r) begin
          calc_mag = MW'(a_r - b_r);
        end else begin
          calc_mag = MW'(b_r - a_r);
          calc_neg = 1'b1;
        end
      end
`ifdef CALC_MUL_EN
      2'b10: calc_mag = MW'(a_r) * MW'(b_r);
`else
      2'b10: calc_err = 1'b1;
`endif
      default: calc_err = 1'b1;
    endcase
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift {shift, mag} left.
  always_comb begin
    adj = shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = shift[4*i +: 4] + 4'd3;
      end
    end
    out_bit    = adj[BW-1];
    shift_next = {adj[BW-2:0], mag[MW-1]};
    mag_next   = {mag[MW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      mag    <= '0;
      shift  <= '0;
      cnt    <= '0;
      neg_r  <= 1'b0;
      err_r  <= 1'b0;
      sticky <= 1'b0;
      bcd    <= '0;
      sinal  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      erro   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= {o1, o0};
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          mag    <= calc_mag;
          neg_r  <= calc_neg;
          err_r  <= calc_err;
          shift  <= '0;
          sticky <= 1'b0;
          cnt    <= '0;
          state  <= CONV;
        end
        CONV: begin
          shift  <= shift_next;
          mag    <= mag_next;
          sticky <= sticky | out_bit;
          cnt    <= cnt + 1'b1;
          // Last shift: publish the result on the edge that enters DONE.
          if (cnt == CW'(MW - 1)) begin
            bcd   <= shift_next;
            ovf   <= sticky | out_bit;
            sinal <= neg_r;
            erro  <= err_r;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
